// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces a raw active-low pushbutton.
// It produces registered press/release/long/repeat strobes, the debounced
// level, and a long-hold flag. The strobes are meant to be used as synchronous
// enables in the clk domain, never as clocks.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic level,
  output logic long_held
);

  // Every counter shares one width, sized by the largest period. Each counter
  // stops at its own terminal value, so it never wraps past it.
  localparam int MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_P  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    LONG,
    REL_WAIT
  } state_t;

  state_t        state;
  logic          key_meta;
  logic          ks;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hold;
  logic [CW-1:0] rep;
  logic          from_long;

  // Two-flop synchronizer. The flops idle at 1 (released), so a reset never
  // produces a phantom press edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta <= 1'b1;
      ks       <= 1'b1;
    end else begin
      key_meta <= key_n;
      ks       <= key_meta;
    end
  end

  // Debounce/long-press FSM with registered outputs. The strobes default low
  // and each branch raises at most one of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      hold          <= '0;
      rep           <= '0;
      from_long     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      level         <= 1'b0;
      long_held     <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (!ks) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (ks) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state       <= PRESSED;
            hold        <= '0;
            press_pulse <= 1'b1;
            level       <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        PRESSED: begin
          // While the release is being qualified, hold stays frozen.
          if (ks) begin
            state     <= REL_WAIT;
            cnt       <= '0;
            from_long <= 1'b0;
          end else if (hold == LONG_LAST) begin
            state      <= LONG;
            rep        <= '0;
            long_pulse <= 1'b1;
            long_held  <= 1'b1;
          end else begin
            hold <= hold + ONE;
          end
        end
        LONG: begin
          if (ks) begin
            state     <= REL_WAIT;
            cnt       <= '0;
            from_long <= 1'b1;
          end else if (rep == REP_LAST) begin
            rep          <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            rep <= rep + ONE;
          end
        end
        REL_WAIT: begin
          // A release glitch resumes the previous phase silently.
          if (!ks) begin
            state <= from_long ? LONG : PRESSED;
          end else if (cnt == DB_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            level         <= 1'b0;
            long_held     <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner. A run-length reference model is compared
// against the DUT every cycle. Directed scenarios pin exact pulse cycles,
// and a randomized key/reset phase follows.
module tb_key_conditioner;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic key_n = 1'b1;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, level, long_held;

  key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .level        (level),
    .long_held    (long_held)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model. The model tracks the run length of the synchronised key.
  // It accepts an edge after D+1 equal samples (the first sample arms the
  // debounce and D more confirm it). While pressed, it counts samples where
  // the key stayed down. Long is reached at count L, and a repeat occurs
  // every R counts after that.
  logic q0 = 1'b1, q1 = 1'b1, last_ks = 1'b1;
  int   run = 1, ccount = 0;
  logic m_deb = 1'b0, m_long = 1'b0;
  logic m_press = 1'b0, m_rel = 1'b0, m_lp = 1'b0, m_rep = 1'b0;

  task automatic model_reset();
    q0 = 1'b1; q1 = 1'b1; last_ks = 1'b1; run = 1; ccount = 0;
    m_deb = 1'b0; m_long = 1'b0;
    m_press = 1'b0; m_rel = 1'b0; m_lp = 1'b0; m_rep = 1'b0;
  endtask

  task automatic model_step();
    logic ks_used;
    ks_used = q1;
    q1 = q0;
    q0 = key_n;
    if (ks_used == last_ks) run++;
    else run = 1;
    last_ks = ks_used;
    m_press = 1'b0; m_rel = 1'b0; m_lp = 1'b0; m_rep = 1'b0;
    if (!m_deb && !ks_used && run == D + 1) begin
      m_deb = 1'b1; m_press = 1'b1; ccount = 0;
    end else if (m_deb && ks_used && run == D + 1) begin
      m_deb = 1'b0; m_rel = 1'b1; m_long = 1'b0;
    end else if (m_deb && !ks_used && run >= 2) begin
      ccount++;
      if (ccount == L) begin
        m_lp = 1'b1; m_long = 1'b1;
      end else if (ccount > L && (ccount - L) % R == 0) begin
        m_rep = 1'b1;
      end
    end
  endtask

  always begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else model_step();
  end

  always begin
    @(posedge clk);
    ecnt++;
  end

  // Per-cycle comparison plus event logging for the directed checks.
  int n_press = 0, n_rel = 0, n_long = 0, n_low = 0;
  int press_at = -1, release_at = -1, long_at = -1;
  int rep_q[$];

  always begin
    @(negedge clk);
    if (chk_en) begin
      check("outputs", int'({press_pulse, release_pulse, long_pulse, repeat_pulse, level, long_held}),
            int'({m_press, m_rel, m_lp, m_rep, m_deb, m_long}));
      check("one_pulse_max",
            int'($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) > 1), 0);
    end
    if (press_pulse)   begin n_press++; press_at = ecnt; end
    if (release_pulse) begin n_rel++;   release_at = ecnt; end
    if (long_pulse)    begin n_long++;  long_at = ecnt; end
    if (repeat_pulse)  rep_q.push_back(ecnt);
    if (!level)        n_low++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int base, base3, p_at, n0, n0r, nl0, len;

  initial begin
    rst = 1'b0; key_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({press_pulse, release_pulse, long_pulse, repeat_pulse, level, long_held}), 0);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    step(5);

    // Clean press, long press and repeats.
    key_n = 1'b0; base = ecnt; n0 = n_press; rep_q.delete();
    step(45);
    check("press_at",   press_at, base + 7);
    check("press_once", n_press - n0, 1);
    check("long_at",    long_at, base + 27);
    check("rep_count",  rep_q.size(), 3);
    if (rep_q.size() >= 3) begin
      check("rep0_at", rep_q[0], base + 32);
      check("rep1_at", rep_q[1], base + 37);
      check("rep2_at", rep_q[2], base + 42);
    end
    check("level_held",     int'(level), 1);
    check("long_held_high", int'(long_held), 1);

    // Release from long press.
    key_n = 1'b1; base = ecnt; n0r = n_rel;
    step(10);
    check("release_at",   release_at, base + 7);
    check("release_once", n_rel - n0r, 1);
    check("level_low",    int'(level), 0);
    check("long_held_low", int'(long_held), 0);

    // Bounce while pressing.
    key_n = 1'b0; base = ecnt; n0 = n_press;
    step(3); key_n = 1'b1;
    step(1); key_n = 1'b0; base3 = ecnt;
    step(6);
    check("bounce_no_early_press", n_press - n0, 0);
    step(1);
    check("bounce_press_once", n_press - n0, 1);
    check("bounce_press_at",   press_at, base3 + 7);
    p_at = press_at;

    // Release glitch while pressed.
    n0r = n_rel; nl0 = n_low;
    step(5); key_n = 1'b1;
    step(2); key_n = 1'b0;
    step(30);
    check("glitch_no_release", n_rel - n0r, 0);
    check("glitch_level_kept", n_low - nl0, 0);
    check("glitch_long_at",    long_at, p_at + 23);

    // Asynchronous reset during long press, key still held.
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({press_pulse, release_pulse, long_pulse, repeat_pulse, level, long_held}), 0);
    @(negedge clk); #1 rst = 1'b1;
    base = ecnt; n0 = n_press; n0r = n_rel;
    step(6);
    check("post_reset_no_early_press", n_press - n0, 0);
    step(1);
    check("post_reset_press_at", press_at, base + 7);
    key_n = 1'b1;
    step(12);
    check("post_reset_release_once", n_rel - n0r, 1);

    // Randomized key activity, with occasional resets.
    for (int s = 0; s < 300; s++) begin
      key_n = 1'(($urandom_range(0, 3) == 0) ? 1 : $urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) len = $urandom_range(20, 60);
      else len = $urandom_range(1, 7);
      step(len);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk); #1 rst = 1'b1;
      end
    end
    key_n = 1'b1;
    step(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
